// File: rtl/vector_rescale_add.sv
// Element-serial vector adder/subtractor: Res = sat((A >>> SHIFT) +/- B), one element
// per enabled cycle, with a done pulse and a sticky saturation flag.
module vector_rescale_add #(
   parameter int WIDTH = 16,
   parameter int nos   = 4,
   parameter int SHIFT = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clk_en,
   input  logic                   startAdd,
   input  logic                   subtract,
   input  logic [nos*WIDTH-1:0]   A,
   input  logic [nos*WIDTH-1:0]   B,
   output logic [nos*WIDTH-1:0]   Res,
   output logic                   endAdd,
   output logic                   ovf
);

   localparam int IW = (nos > 1) ? $clog2(nos) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(nos - 1);

   typedef enum logic [1:0] {IDLE, ONADD, ENDADD} state_t;

   state_t                   state;
   logic [IW-1:0]            idx;
   logic                     op;
   logic signed [WIDTH-1:0]  a_el [nos];
   logic signed [WIDTH-1:0]  b_el [nos];
   logic signed [WIDTH-1:0]  res_el [nos];

   logic signed [WIDTH-1:0]  a_sh;
   logic signed [WIDTH-1:0]  b_cur;
   logic        [WIDTH:0]    sum_w;
   logic                     clip;
   logic        [WIDTH-1:0]  sat_val;

   genvar gi;
   generate
      for (gi = 0; gi < nos; gi++) begin : g_elem
         assign a_el[gi] = A[gi*WIDTH +: WIDTH];
         assign b_el[gi] = B[gi*WIDTH +: WIDTH];
         assign Res[gi*WIDTH +: WIDTH] = res_el[gi];
      end
   endgenerate

   // One extra bit of headroom: overflow shows up as the top two bits disagreeing.
   always_comb begin
      a_sh  = a_el[idx] >>> SHIFT;
      b_cur = b_el[idx];
      if (op)
         sum_w = {a_sh[WIDTH-1], a_sh} - {b_cur[WIDTH-1], b_cur};
      else
         sum_w = {a_sh[WIDTH-1], a_sh} + {b_cur[WIDTH-1], b_cur};
      clip = sum_w[WIDTH] ^ sum_w[WIDTH-1];
      if (!clip)
         sat_val = sum_w[WIDTH-1:0];
      else if (sum_w[WIDTH])
         sat_val = {1'b1, {(WIDTH-1){1'b0}}};
      else
         sat_val = {1'b0, {(WIDTH-1){1'b1}}};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         idx    <= '0;
         op     <= 1'b0;
         ovf    <= 1'b0;
         endAdd <= 1'b0;
         for (int i = 0; i < nos; i++) res_el[i] <= '0;
      end else if (clk_en) begin
         case (state)
            IDLE: begin
               endAdd <= 1'b0;
               if (startAdd) begin
                  state <= ONADD;
                  idx   <= '0;
                  op    <= subtract;
                  ovf   <= 1'b0;
                  for (int i = 0; i < nos; i++) res_el[i] <= '0;
               end
            end
            ONADD: begin
               res_el[idx] <= sat_val;
               if (clip) ovf <= 1'b1;
               if (idx == LAST_IDX) begin
                  state  <= ENDADD;
                  endAdd <= 1'b1;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            ENDADD: begin
               // A start arriving here is dropped; only IDLE accepts requests.
               state  <= IDLE;
               endAdd <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               endAdd <= 1'b0;
            end
         endcase
      end
   end

endmodule
